// File: rtl/spi_reg_master_pkg.sv
// spi_reg_pkg: shared definitions for the SPI register master.
//   state_e       - controller states
//   CNT_W         - width of the generic phase counter (setup/hold/idle)
//   frame_len()   - bits per frame: rd_nwr + address + data
//   rw_bit_pos()  - frame bit index of rd_nwr (the frame MSB)
//   addr_lsb_pos()- frame bit index of the address LSB
package spi_reg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_e;

    localparam int CNT_W = 16;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int rw_bit_pos(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

    function automatic int addr_lsb_pos(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/spi_reg_master_if.sv
// spi_reg_master_if: host-side request/response bundle of the SPI register master.
//   start, rd_nwr, addr, wdata : request from the host (captured on accept)
//   busy, done, rdata          : status and read result back to the host
// modport master: the host issuing frames; modport slave: the SPI master block.
interface spi_reg_master_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              start;
    logic              rd_nwr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output start, rd_nwr, addr, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  start, rd_nwr, addr, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/spi_reg_master_clk_div.sv
// spi_clk_div: serial clock generator for the SPI register master.
//   clk, rst_n   : system clock, async active-low reset
//   en_i         : run the divider; when low the phase restarts low
//   spi_clk_o    : registered serial clock, CLK_DIV cycles low then CLK_DIV high
//   rise_tick_o  : high in the cycle whose closing edge raises spi_clk_o
//   fall_tick_o  : high in the cycle whose closing edge lowers spi_clk_o
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic spi_clk_o,
    output logic rise_tick_o,
    output logic fall_tick_o
);
    localparam int DW = $clog2(CLK_DIV + 1);

    logic [DW-1:0] cnt_q;
    logic          clk_q;
    logic          last;

    assign last        = en_i && (cnt_q == DW'(CLK_DIV - 1));
    assign rise_tick_o = last && !clk_q;
    assign fall_tick_o = last && clk_q;
    assign spi_clk_o   = clk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else if (last) begin
            cnt_q <= '0;
            clk_q <= ~clk_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/spi_reg_master.sv
// spi_reg_master: mode-0, MSB-first SPI initiator issuing one register
// read or write frame (rd_nwr, addr, data) per chip-select assertion.
//   clk, rst_n : system clock, async active-low reset
//   host       : request/response bundle (slave modport)
//   spi_cs     : chip select, active low
//   spi_clk    : serial clock, idles low
//   spi_mosi   : serial data out
//   spi_miso   : serial data in, double-flop synchronized here
module spi_reg_master
    import spi_reg_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    spi_reg_master_if.slave         host,
    output logic                    spi_cs,
    output logic                    spi_clk,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);
    localparam int N   = frame_len(ADDR_W, DATA_W);
    localparam int MSB = rw_bit_pos(ADDR_W, DATA_W);
    localparam int BW  = $clog2(N);

    // The two-cycle synchronizer delay must resolve before the next falling edge.
    if (CLK_DIV < 3 || CS_SETUP < 1 || CS_HOLD < 1 || CS_IDLE < 1) begin : g_bad_param
        $error("spi_reg_master: CLK_DIV must be >= 3 and CS_* counts >= 1");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rd_q, rd_d;
    logic [N-1:0]      tx_q, tx_d;
    logic [DATA_W-1:0] rx_q;
    logic              miso_s1_q, miso_s2_q;
    logic              rise_d1_q, rise_d2_q;
    logic              rise_tick, fall_tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (state_q == S_SHIFT),
        .spi_clk_o   (spi_clk),
        .rise_tick_o (rise_tick),
        .fall_tick_o (fall_tick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        tx_d    = tx_q;
        case (state_q)
            S_IDLE: begin
                if (host.start) begin
                    // Read frames carry zeros in the data field.
                    tx_d    = {host.rd_nwr, host.addr, host.wdata & {DATA_W{~host.rd_nwr}}};
                    rd_d    = host.rd_nwr;
                    mosi_d  = tx_d[MSB];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (fall_tick) begin
                    if (bit_q == BW'(N - 1)) begin
                        mosi_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = S_HOLD;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        tx_d   = {tx_q[N-2:0], 1'b0};
                        mosi_d = tx_q[N-2];
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD - 1)) begin
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    if (rd_q) begin
                        rdata_d = rx_q;
                    end
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            rise_d1_q <= 1'b0;
            rise_d2_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
            // Delay the rise tick to match the synchronizer: the pin value at
            // the spi_clk rising edge reaches miso_s2_q two cycles later.
            rise_d1_q <= rise_tick;
            rise_d2_q <= rise_d1_q;
        end
    end

    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        rd_q <= rd_d;
        if (rise_d2_q) begin
            rx_q <= {rx_q[DATA_W-2:0], miso_s2_q};
        end
    end

    assign spi_cs     = cs_q;
    assign spi_mosi   = mosi_q;
    assign host.busy  = busy_q;
    assign host.done  = done_q;
    assign host.rdata = rdata_q;
endmodule

// File: tb/tb_spi_reg_master.sv
module tb_spi_reg_master;
    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_IDLE  = 2;
    localparam int NB       = 16;
    localparam int SHIFT_LEN = 2 * CLK_DIV * NB;
    localparam int LOW_LEN  = CS_SETUP + SHIFT_LEN + CS_HOLD;

    logic clk = 1'b0;
    logic rst_n;
    logic spi_cs, spi_clk, spi_mosi;
    logic spi_miso = 1'b0;

    always #5 clk = ~clk;

    spi_reg_master_if #(.ADDR_W(7), .DATA_W(8)) ifc ();

    spi_reg_master #(
        .CLK_DIV(CLK_DIV), .ADDR_W(7), .DATA_W(8),
        .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (ifc),
        .spi_cs   (spi_cs),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- register-file slave on the SPI pins ----------------
    logic [7:0]  slv_regs [128];
    logic [15:0] sl_sh;
    int          sl_cnt;
    logic [7:0]  sl_rdv;

    always @(negedge spi_cs) begin
        sl_cnt = 0;
        sl_sh  = '0;
    end

    always @(posedge spi_clk) begin
        sl_sh = {sl_sh[14:0], spi_mosi};
        sl_cnt++;
        if (sl_cnt == 16 && !sl_sh[15]) slv_regs[sl_sh[14:8]] = sl_sh[7:0];
    end

    always @(negedge spi_clk) begin
        if (sl_cnt == 8) sl_rdv = slv_regs[sl_sh[6:0]];
        if (sl_cnt >= 8 && sl_cnt < 16) spi_miso = sl_rdv[15 - sl_cnt];
        else spi_miso = 1'b0;
    end

    // ---------------- timeline model ----------------
    // m_k counts cycles since the accepting edge (1 = first cycle with cs low);
    // -1 means the block is idle and will accept start at the next edge.
    int          m_k = -1;
    logic [15:0] m_frame = '0;
    logic        m_rd = 1'b0;
    logic [7:0]  m_rdata = '0;
    logic [7:0]  model_regs [128];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k     = -1;
            m_rdata = '0;
        end else if (m_k < 0) begin
            if (ifc.start) begin
                m_k     = 1;
                m_rd    = ifc.rd_nwr;
                m_frame = {ifc.rd_nwr, ifc.addr, ifc.rd_nwr ? 8'h00 : ifc.wdata};
            end
        end else begin
            m_k++;
            if (m_k == LOW_LEN + 1) begin
                if (m_rd) m_rdata = model_regs[m_frame[14:8]];
                else      model_regs[m_frame[14:8]] = m_frame[7:0];
            end
            if (m_k > LOW_LEN + CS_IDLE) m_k = -1;
        end
    end

    // {cs, spi_clk, mosi, busy, done} expected k cycles into a frame
    function automatic logic [4:0] exp_pins(input int k, input logic [15:0] f);
        int j;
        if (k < 0)                        return 5'b10000;
        if (k <= CS_SETUP)                return {1'b0, 1'b0, f[15], 1'b1, 1'b0};
        if (k <= CS_SETUP + SHIFT_LEN) begin
            j = k - 1 - CS_SETUP;
            return {1'b0, (j % (2*CLK_DIV)) >= CLK_DIV, f[15 - j/(2*CLK_DIV)], 1'b1, 1'b0};
        end
        if (k <= LOW_LEN)                 return 5'b00010;
        return {1'b1, 1'b0, 1'b0, 1'b1, k == LOW_LEN + 1};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pins{cs,sclk,mosi,busy,done}", {spi_cs, spi_clk, spi_mosi, ifc.busy, ifc.done},
                  exp_pins(m_k, m_frame));
            check("rdata", ifc.rdata, m_rdata);
        end
    end

    // ---------------- window / pulse tracking ----------------
    int done_cnt = 0, windows = 0, cur_low = 0, cur_high = 0, last_low = 0, last_high = 0;

    always @(posedge clk) begin
        if (cmp_en) begin
            if (ifc.done) done_cnt++;
            if (!spi_cs) begin
                if (cur_high != 0) begin
                    last_high = cur_high;
                    cur_high  = 0;
                    windows++;
                end
                cur_low++;
            end else begin
                if (cur_low != 0) begin
                    last_low = cur_low;
                    cur_low  = 0;
                end
                cur_high++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(output logic [7:0] rd_at_done);
        int i = 0;
        while (!ifc.done && i < 400) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", ifc.done, 1'b1);
        rd_at_done = ifc.rdata;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (ifc.busy && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic do_frame(input logic rd, input logic [6:0] a, input logic [7:0] wd,
                            output logic [7:0] rd_at_done, output int gap);
        @(negedge clk);
        ifc.start = 1'b1; ifc.rd_nwr = rd; ifc.addr = a; ifc.wdata = wd;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done(rd_at_done);
        wait_idle(gap);
        check("busy_released", ifc.busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rdv;
        int gap, d0, w0, dn;

        for (int i = 0; i < 128; i++) begin
            slv_regs[i]   = 8'h00;
            model_regs[i] = 8'h00;
        end
        slv_regs[5]   = 8'hA5;
        model_regs[5] = 8'hA5;
        ifc.start = 1'b0; ifc.rd_nwr = 1'b0; ifc.addr = '0; ifc.wdata = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pins", {spi_cs, spi_clk, spi_mosi, ifc.busy, ifc.done}, 5'b10000);
        check("reset_rdata", ifc.rdata, 8'h00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // write 0x5A to 0x12
        d0 = done_cnt;
        do_frame(1'b0, 7'h12, 8'h5A, rdv, gap);
        check("wr_mosi_bits", sl_sh, 16'h125A);
        check("wr_rises", sl_cnt, 16);
        check("wr_cs_low", last_low, LOW_LEN);
        check("wr_done_pulses", done_cnt - d0, 1);
        check("wr_rdata_kept", ifc.rdata, 8'h00);

        // read 0x05 -> slave returns 0xA5
        do_frame(1'b1, 7'h05, 8'hFF, rdv, gap);
        check("rd_mosi_bits", sl_sh, 16'h8500);
        check("rd_rdata_at_done", rdv, 8'hA5);
        check("rd_done_to_idle", gap, CS_IDLE);

        // start pulsed mid-SHIFT is ignored
        d0 = done_cnt; w0 = windows;
        @(negedge clk);
        ifc.start = 1'b1; ifc.rd_nwr = 1'b0; ifc.addr = 7'h33; ifc.wdata = 8'h11;
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (40) @(negedge clk);
        ifc.start = 1'b1; ifc.rd_nwr = 1'b1; ifc.addr = 7'h05;
        @(negedge clk);
        ifc.start = 1'b0;
        wait_done(rdv);
        wait_idle(gap);
        repeat (20) @(negedge clk);
        check("busy_start_windows", windows - w0, 1);
        check("busy_start_dones", done_cnt - d0, 1);
        check("busy_start_rdata", ifc.rdata, 8'hA5);

        // start held for three back-to-back frames
        d0 = done_cnt; w0 = windows; dn = 0;
        @(negedge clk);
        ifc.start = 1'b1; ifc.rd_nwr = 1'b0; ifc.addr = 7'h40; ifc.wdata = 8'h77;
        for (int i = 0; i < 600 && dn < 3; i++) begin
            @(negedge clk);
            if (ifc.done) dn++;
        end
        ifc.start = 1'b0;
        wait_idle(gap);
        repeat (3) @(negedge clk);
        check("held_dones_seen", dn, 3);
        check("held_done_count", done_cnt - d0, 3);
        check("held_windows", windows - w0, 3);
        check("held_cs_gap", last_high, CS_IDLE + 1);

        // asynchronous reset in the middle of a frame
        d0 = done_cnt;
        @(negedge clk);
        ifc.start = 1'b1; ifc.rd_nwr = 1'b0; ifc.addr = 7'h2A; ifc.wdata = 8'hC3;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 200 && sl_cnt < 7; i++) @(negedge clk);
        check("abort_reached_bit7", sl_cnt, 7);
        #2 rst_n = 1'b0;
        #1 check("abort_async_pins", {spi_cs, spi_clk, spi_mosi, ifc.busy, ifc.done}, 5'b10000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        do_frame(1'b1, 7'h12, 8'h00, rdv, gap);
        check("post_abort_mosi_bits", sl_sh, 16'h9200);
        check("post_abort_rises", sl_cnt, 16);
        check("post_abort_cs_low", last_low, LOW_LEN);
        check("post_abort_rdata", rdv, 8'h5A);

        // write then read back a scratch register
        do_frame(1'b0, 7'h7E, 8'h3C, rdv, gap);
        do_frame(1'b1, 7'h7E, 8'h00, rdv, gap);
        check("loopback_rdata", rdv, 8'h3C);

        repeat (5) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
